// File: rtl/bitserial_nn.sv
// Bit-serial fully-connected layer with ReLU: P neuron lanes consume one input bit per cycle.
// The input vector arrives on an AXI-Stream slave and results leave on an AXI-Stream master.
module bitserial_nn #(
   parameter  int DATA_W    = 16,
   parameter  int PRECISION = DATA_W,
   parameter  int N_IN      = 128,
   parameter  int N_HIDDEN  = 64,
   parameter  int P         = 4,
   localparam int IN_AW     = $clog2(N_IN > 2 ? N_IN : 2),
   localparam int H_AW      = $clog2(N_HIDDEN > 2 ? N_HIDDEN : 2),
   localparam int ACC_W     = 2*DATA_W + IN_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic              s_axis_tlast,
   input  logic              w_wr_en,
   input  logic [H_AW-1:0]   w_addr_h,
   input  logic [IN_AW-1:0]  w_addr_i,
   input  logic [DATA_W-1:0] w_data,
   output logic [ACC_W-1:0]  m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic              busy
);

   localparam int G    = N_HIDDEN / P;
   localparam int G_AW = $clog2(G > 2 ? G : 2);
   localparam int K_AW = $clog2(P > 2 ? P : 2);
   localparam int B_AW = $clog2(PRECISION > 2 ? PRECISION : 2);

   typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_OUTPUT} state_t;

   state_t                  state_q, state_d;
   logic [G_AW-1:0]         g_q, g_d;
   logic [IN_AW-1:0]        i_q, i_d;
   logic [B_AW-1:0]         b_q, b_d;
   logic [K_AW-1:0]         k_q, k_d;
   logic [IN_AW-1:0]        cnt_q, cnt_d;
   logic [IN_AW:0]          len_q, len_d;
   logic signed [ACC_W-1:0] acc_q [P];
   logic signed [ACC_W-1:0] acc_d [P];
   logic [ACC_W-1:0]        tdata_q, tdata_d;
   logic                    tvalid_q, tvalid_d;
   logic                    tlast_q, tlast_d;
   logic                    s_ready_q, s_ready_d;
   logic                    busy_q, busy_d;

   // Weight bank k holds every neuron h with h % P == k, so one group reads all lanes at once.
   logic [DATA_W-1:0]        w_mem [P][G][N_IN];
   logic [DATA_W-1:0]        x_mem [N_IN];
   logic signed [DATA_W-1:0] w_rd_q [P];
   logic [DATA_W-1:0]        x_rd_q;

   logic            w_we, x_we, x_bit;
   logic            last_bit, last_in, last_grp;
   logic [K_AW-1:0] wr_bank, k_nxt;
   logic [G_AW-1:0] wr_grp;

   function automatic logic [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] a);
      return a[ACC_W-1] ? '0 : a;
   endfunction

   assign w_we     = w_wr_en && !busy_q;
   assign wr_bank  = K_AW'(int'(w_addr_h) % P);
   assign wr_grp   = G_AW'(int'(w_addr_h) / P);
   assign last_bit = (b_q == B_AW'(PRECISION-1));
   assign last_in  = (i_q == IN_AW'(N_IN-1));
   assign last_grp = (g_q == G_AW'(G-1));
   assign k_nxt    = k_q + K_AW'(1);
   // Slots past the last accepted beat hold stale data and count as zero.
   assign x_bit    = ({1'b0, i_q} < len_q) && x_rd_q[b_q];

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d   = state_q;
      g_d       = g_q;
      i_d       = i_q;
      b_d       = b_q;
      k_d       = k_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      acc_d     = acc_q;
      tdata_d   = tdata_q;
      tvalid_d  = tvalid_q;
      tlast_d   = tlast_q;
      s_ready_d = s_ready_q;
      busy_d    = busy_q;
      x_we      = 1'b0;
      unique case (state_q)
         ST_LOAD: begin
            if (s_axis_tvalid && s_ready_q) begin
               x_we  = 1'b1;
               cnt_d = cnt_q + IN_AW'(1);
               if (s_axis_tlast || cnt_q == IN_AW'(N_IN-1)) begin
                  len_d     = {1'b0, cnt_q} + (IN_AW+1)'(1);
                  cnt_d     = '0;
                  g_d       = '0;
                  i_d       = '0;
                  b_d       = '0;
                  for (int k = 0; k < P; k++) acc_d[k] = '0;
                  state_d   = ST_COMPUTE;
                  s_ready_d = 1'b0;
                  busy_d    = 1'b1;
               end
            end
         end
         ST_COMPUTE: begin
            // The top input bit carries negative weight in two's complement.
            for (int k = 0; k < P; k++) begin
               if (x_bit) begin
                  if (last_bit) acc_d[k] = acc_q[k] - (ACC_W'(w_rd_q[k]) <<< b_q);
                  else          acc_d[k] = acc_q[k] + (ACC_W'(w_rd_q[k]) <<< b_q);
               end
            end
            if (last_bit) begin
               b_d = '0;
               if (last_in) begin
                  i_d      = '0;
                  k_d      = '0;
                  state_d  = ST_OUTPUT;
                  tdata_d  = relu(acc_d[0]);
                  tvalid_d = 1'b1;
                  tlast_d  = last_grp && (P == 1);
               end else begin
                  i_d = i_q + IN_AW'(1);
               end
            end else begin
               b_d = b_q + B_AW'(1);
            end
         end
         ST_OUTPUT: begin
            if (m_axis_tready) begin
               if (k_q == K_AW'(P-1)) begin
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
                  k_d      = '0;
                  for (int k = 0; k < P; k++) acc_d[k] = '0;
                  if (last_grp) begin
                     g_d       = '0;
                     state_d   = ST_LOAD;
                     s_ready_d = 1'b1;
                     busy_d    = 1'b0;
                  end else begin
                     g_d     = g_q + G_AW'(1);
                     state_d = ST_COMPUTE;
                  end
               end else begin
                  k_d     = k_nxt;
                  tdata_d = relu(acc_q[k_nxt]);
                  tlast_d = last_grp && (k_nxt == K_AW'(P-1));
               end
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // NOTE: memories carry no reset so they map onto RAM; unfilled input slots are masked by len_q.
   // Reads use next-cycle indices so the operands line up with the counters one cycle later.
   always_ff @(posedge clk) begin
      if (w_we) w_mem[wr_bank][wr_grp][w_addr_i] <= w_data;
      if (x_we) x_mem[cnt_q] <= s_axis_tdata;
      for (int k = 0; k < P; k++) begin
         if (w_we && wr_bank == K_AW'(k) && wr_grp == g_d && w_addr_i == i_d) w_rd_q[k] <= w_data;
         else w_rd_q[k] <= w_mem[k][g_d][i_d];
      end
      x_rd_q <= (x_we && cnt_q == i_d) ? s_axis_tdata : x_mem[i_d];
   end

   // NOTE: non-blocking assignments so every flop samples values from before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_LOAD;
         g_q       <= '0;
         i_q       <= '0;
         b_q       <= '0;
         k_q       <= '0;
         cnt_q     <= '0;
         len_q     <= '0;
         for (int k = 0; k < P; k++) acc_q[k] <= '0;
         tdata_q   <= '0;
         tvalid_q  <= 1'b0;
         tlast_q   <= 1'b0;
         s_ready_q <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         g_q       <= g_d;
         i_q       <= i_d;
         b_q       <= b_d;
         k_q       <= k_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         acc_q     <= acc_d;
         tdata_q   <= tdata_d;
         tvalid_q  <= tvalid_d;
         tlast_q   <= tlast_d;
         s_ready_q <= s_ready_d;
         busy_q    <= busy_d;
      end
   end

   assign s_axis_tready = s_ready_q;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_bitserial_nn.sv
// Self-checking bench for bitserial_nn: directed and random vectors against a dot-product model.
module tb_bitserial_nn;

   localparam int DATA_W = 16;
   localparam int N_IN   = 128;
   localparam int N_H    = 8;
   localparam int P      = 4;
   localparam int IA     = 7;
   localparam int HA     = 3;
   localparam int ACC_W  = 39;
   localparam int LIMIT  = 20000;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] s_axis_tdata;
   logic              s_axis_tvalid, s_axis_tready, s_axis_tlast;
   logic              w_wr_en;
   logic [HA-1:0]     w_addr_h;
   logic [IA-1:0]     w_addr_i;
   logic [DATA_W-1:0] w_data;
   logic [ACC_W-1:0]  m_axis_tdata;
   logic              m_axis_tvalid, m_axis_tready, m_axis_tlast;
   logic              busy;

   int                w_ref [N_H][N_IN];
   int                x_ref [N_IN];
   int                n_err = 0;
   int                n_chk = 0;
   logic signed [63:0] out_data [N_H];
   logic              out_last [N_H];
   int                out_cyc  [N_H];

   bitserial_nn #(.DATA_W(DATA_W), .N_IN(N_IN), .N_HIDDEN(N_H), .P(P)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .w_wr_en(w_wr_en), .w_addr_h(w_addr_h), .w_addr_i(w_addr_i), .w_data(w_data),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Exact signed dot product over the accepted samples, wrapped to ACC_W bits, then ReLU.
   function automatic logic signed [63:0] model(input int h, input int n);
      longint s = 0;
      for (int i = 0; i < n; i++) s += longint'(x_ref[i]) * longint'(w_ref[h][i]);
      s = (s <<< (64 - ACC_W)) >>> (64 - ACC_W);
      return (s < 0) ? 64'sd0 : s;
   endfunction

   task automatic load_weights(input int mode);
      for (int h = 0; h < N_H; h++) begin
         for (int i = 0; i < N_IN; i++) begin
            case (mode)
               0:       w_ref[h][i] = 100*h + i;
               1:       w_ref[h][i] = -1;
               2:       w_ref[h][i] = -32768;
               default: w_ref[h][i] = int'($urandom_range(0, 65535)) - 32768;
            endcase
            w_wr_en  = 1'b1;
            w_addr_h = HA'(h);
            w_addr_i = IA'(i);
            w_data   = DATA_W'(w_ref[h][i]);
            tick();
         end
      end
      w_wr_en = 1'b0;
   endtask

   task automatic stream(input int n, input string tag);
      for (int j = 0; j < n; j++) begin
         int w = 0;
         s_axis_tdata  = DATA_W'(x_ref[j]);
         s_axis_tvalid = 1'b1;
         s_axis_tlast  = (j == n-1);
         while (!s_axis_tready && w < 100) begin
            tick();
            w++;
         end
         if (j == 0 || j == n-1) check($sformatf("%s/in_ready%0d", tag, j), s_axis_tready, 1);
         tick();
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      check({tag, "/in_closed"}, {s_axis_tready, busy}, 2'b01);
   endtask

   task automatic collect(input int n, input bit rnd_ready, input string tag);
      int got = 0;
      int cyc = 0;
      logic [ACC_W-1:0] held_d;
      logic             held_l;
      while (got < N_H && cyc < LIMIT) begin
         m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (m_axis_tvalid && m_axis_tready) begin
            out_data[got] = {{(64-ACC_W){m_axis_tdata[ACC_W-1]}}, m_axis_tdata};
            out_last[got] = m_axis_tlast;
            out_cyc[got]  = cyc;
            check($sformatf("%s/busy_at_out%0d", tag, got), {s_axis_tready, busy}, 2'b01);
            got++;
            tick();
         end else if (m_axis_tvalid) begin
            held_d = m_axis_tdata;
            held_l = m_axis_tlast;
            tick();
            check({tag, "/hold"}, {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, held_l, held_d});
         end else begin
            tick();
         end
         cyc++;
      end
      m_axis_tready = 1'b0;
      check({tag, "/count"}, got, N_H);
      for (int h = 0; h < got; h++) begin
         check($sformatf("%s/out%0d", tag, h), out_data[h], model(h, n));
         check($sformatf("%s/last%0d", tag, h), out_last[h], (h == N_H-1));
         if (!rnd_ready && (h % P) != 0)
            check($sformatf("%s/gap%0d", tag, h), out_cyc[h] - out_cyc[h-1], 1);
      end
      check({tag, "/back_to_load"}, {s_axis_tready, busy, m_axis_tvalid}, 3'b100);
   endtask

   initial begin
      rst           = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      w_wr_en       = 1'b0;
      w_addr_h      = '0;
      w_addr_i      = '0;
      w_data        = '0;
      m_axis_tready = 1'b0;
      repeat (3) tick();
      check("rst/tready", s_axis_tready, 1);
      check("rst/tvalid", m_axis_tvalid, 0);
      check("rst/tlast",  m_axis_tlast, 0);
      check("rst/tdata",  m_axis_tdata, 0);
      check("rst/busy",   busy, 0);
      rst = 1'b0;
      tick();

      // Ramp weights and ramp input, closed-form results.
      load_weights(0);
      for (int i = 0; i < N_IN; i++) x_ref[i] = i;
      stream(N_IN, "ramp");
      collect(N_IN, 1'b0, "ramp");
      check("ramp/h0_closed", out_data[0], 64'sd690880);
      check("ramp/h7_closed", out_data[7], 64'sd812800 * 7 + 64'sd690880);

      // Random backpressure, plus a weight write attempted while busy that must be ignored.
      stream(N_IN, "bp");
      w_wr_en  = 1'b1;
      w_addr_h = HA'(1);
      w_addr_i = IA'(5);
      w_data   = 16'h7fff;
      tick();
      w_wr_en  = 1'b0;
      collect(N_IN, 1'b1, "bp");

      // Early tlast after four samples; stale buffer slots must read as zero.
      for (int i = 0; i < 4; i++) x_ref[i] = i + 1;
      stream(4, "early");
      collect(4, 1'b0, "early");
      check("early/h1_closed", out_data[1], 64'sd1020);

      // Reset in the middle of computation, then rerun without reloading weights.
      for (int i = 0; i < N_IN; i++) x_ref[i] = i;
      stream(N_IN, "abort");
      repeat (1000) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort/state", {s_axis_tready, busy, m_axis_tvalid}, 3'b100);
      stream(N_IN, "rerun");
      collect(N_IN, 1'b0, "rerun");

      // Negative weights: ReLU clamp, then negative inputs.
      load_weights(1);
      stream(N_IN, "relu");
      collect(N_IN, 1'b0, "relu");
      check("relu/h3_closed", out_data[3], 0);
      for (int i = 0; i < N_IN; i++) x_ref[i] = -1;
      stream(N_IN, "neg");
      collect(N_IN, 1'b0, "neg");
      check("neg/h5_closed", out_data[5], 128);

      // Most negative operands everywhere.
      load_weights(2);
      for (int i = 0; i < N_IN; i++) x_ref[i] = -32768;
      stream(N_IN, "ext");
      collect(N_IN, 1'b0, "ext");
      check("ext/h0_closed", out_data[0], 64'sd137438953472);

      // Random weights and inputs, full and short vectors, random backpressure.
      load_weights(3);
      for (int i = 0; i < N_IN; i++) x_ref[i] = int'($urandom_range(0, 65535)) - 32768;
      stream(N_IN, "rnd_full");
      collect(N_IN, 1'b1, "rnd_full");
      begin
         int n = int'($urandom_range(1, N_IN-1));
         for (int i = 0; i < N_IN; i++) x_ref[i] = int'($urandom_range(0, 65535)) - 32768;
         stream(n, "rnd_short");
         collect(n, 1'b1, "rnd_short");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/bitserial_nn.md
Name: bitserial_nn

Overview:
Single fully-connected neural layer (N_IN inputs -> N_HIDDEN neurons) with ReLU, computed bit-serially over the input bits. P neurons are processed in parallel per pass. Takes one input vector on an AXI-Stream slave and returns one N_HIDDEN-word result vector on an AXI-Stream master. Weights are loaded through a simple write port into on-chip memory.

Parameters:
DATA_W, 16, width of input samples and weights (signed two's complement)
PRECISION, DATA_W, number of input bits processed serially (1..DATA_W)
N_IN, 128, input vector length
N_HIDDEN, 64, number of neurons/outputs; must be a multiple of P
P, 4, parallel neuron lanes
ACC_W (derived, localparam), 2*DATA_W+clog2(max(N_IN,2)) = 39, output/accumulator width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
s_axis_tdata  in  DATA_W  signed input sample
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last sample of vector
w_wr_en  in  1  weight write strobe
w_addr_h  in  clog2(max(N_HIDDEN,2))  neuron index
w_addr_i  in  clog2(max(N_IN,2))  input index
w_data  in  DATA_W  signed weight W[h][i]
m_axis_tdata  out  ACC_W  signed result, ReLU applied
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  high with neuron N_HIDDEN-1 result
busy  out  1  high in any state other than IDLE/LOAD

Behaviour:
- Reset: state=LOAD, s_axis_tready=1, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, counters/accumulators cleared. Weight memory and input buffer are not cleared. Reset mid-computation aborts and returns to LOAD.
- Weight write: w_wr_en high at posedge stores w_data at W[w_addr_h][w_addr_i] (N_HIDDEN*N_IN words). Writes accepted only when busy=0; ignored while busy.
- LOAD: s_axis_tready=1; each tvalid&tready beat stores sample into buffer slot cnt (0..N_IN-1). Transition to COMPUTE after beat with tlast=1 or when N_IN-th beat is taken, whichever first. Early tlast: unfilled slots treated as 0. Extra beats never accepted (tready=0 outside LOAD).
- COMPUTE: s_axis_tready=0, busy=1. Neurons processed in groups g=0..N_HIDDEN/P-1, lanes h=g*P+k. Per group, per input i (0..N_IN-1), per bit b (0..PRECISION-1), one cycle: if x[i] bit b set, acc_k += W[h][i]<<b, except bit PRECISION-1 which subtracts (two's-complement sign weight). Accumulators are ACC_W-bit signed with sign-extended weights; the result equals the exact signed dot product sum_i x[i]*W[h][i], truncated to ACC_W bits. Cycles per group = N_IN*PRECISION (2048 default); total compute <= 40000 cycles at defaults.
- ReLU: result<0 -> 0; else result.
- OUTPUT: after each group, P results emitted in ascending h, one per handshake. m_axis_tdata/tvalid/tlast held stable until m_axis_tready. Computation of the next group stalls until all P are accepted. m_axis_tlast=1 only for h=N_HIDDEN-1.
- After the last handshake: return to LOAD, busy=0, s_axis_tready=1 on next cycle; weights persist for the next vector.
- With m_axis_tready constantly high, one output per cycle during emission; no gaps within a group.

Test Plan:
- Load W[h][i]=100h+i for all h,i; stream x[i]=i (tlast at i=127), m_axis_tready=1 -> 64 outputs in order, out[h]=812800h+690880 (h=0: 690880, h=63: 51897280), tlast only on 64th, all within 500000 cycles.
- All weights -1, x[i]=i -> every output 0 (ReLU clamp); weights -1 with x[i]=-1 -> every output 128.
- Signed extremes: W=-32768, x=-32768 all i -> each out = 128*2^30 = 137438953472 (fits 39-bit signed).
- Backpressure: m_axis_tready toggled randomly -> same 64 values, no drop/duplicate, tdata stable while tvalid&!tready.
- Early tlast after 4 samples x=1,2,3,4, W=100h+i -> out[h]=1000h+20; s_axis_tready low and busy high until last output accepted.
- Assert rst mid-COMPUTE for one cycle -> busy=0, m_axis_tvalid=0, tready=1 next cycle; re-stream vector from test 1 -> correct results without reloading weights.
